// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_NWR   = 1;
    localparam int AW        = $clog2(DEF_NREGS);

    typedef logic [AW-1:0]       reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on writeback, bit 0 tied to 0.
// An issue and a writeback to the same register in one cycle leave the bit set.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [RAW-1:0]       set_addr,
    input  logic [NWR-1:0]       clr_en,
    input  logic [NWR*RAW-1:0]   clr_addr,
    input  logic [NRD*RAW-1:0]   rd_addr,
    output logic [NRD-1:0]       rd_busy,
    output logic                 any_busy
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;

    // Next busy state: clears from writeback first, then the issue set so it wins.
    always_comb begin
        // NOTE: assign a default before any conditional update so no latch is inferred.
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (clr_en[j]) busy_nxt[clr_addr[j*RAW +: RAW]] = 1'b0;
        end
        if (set_en) busy_nxt[set_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy register with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    // Busy lookup per read port and drain indicator.
    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy[i] = busy[rd_addr[i*RAW +: RAW]];
        end
        any_busy = |busy;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired-zero x0 and busy scoreboard.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    parameter int NWR   = DEF_NWR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iss_en,
    input  logic [$clog2(NREGS)-1:0] iss_rd,
    output logic                 any_busy
);

    localparam int RAW = $clog2(NREGS);

    logic [XLEN-1:0] mem [NREGS];
    logic [NRD-1:0]  sb_busy;
    logic [NWR-1:0]  wr_live;

    // Writes to x0 never reach the array or the scoreboard.
    always_comb begin
        wr_live = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_live[j] = wr_en[j] && (wr_addr[j*RAW +: RAW] != '0);
        end
    end

    // Data array; later ports in the loop override earlier ones, so the highest index wins.
    always_ff @(posedge clock) begin
        // NOTE: the array is reset because architectural state must read 0 after reset.
        if (reset) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_live[j]) mem[wr_addr[j*RAW +: RAW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR),
        .RAW   (RAW)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (iss_en),
        .set_addr (iss_rd),
        .clr_en   (wr_live),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy),
        .any_busy (any_busy)
    );

    // Combinational read ports with x0 forced to zero and optional forwarding.
    always_comb begin
        rd_data = '0;
        rd_busy = sb_busy;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i*RAW +: RAW] != '0) begin
                rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*RAW +: RAW]];
            end
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
                if (wr_live[j] && (wr_addr[j*RAW +: RAW] == rd_addr[i*RAW +: RAW])) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    rd_busy[i] = iss_en && (iss_rd == rd_addr[i*RAW +: RAW]);
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_rd;
    logic                 any_busy;

    int total = 0;
    int bad   = 0;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .any_busy (any_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en  = '0;
        iss_en = 1'b0;
        iss_rd = '0;
    endtask

    task automatic wr(input int port, input logic [AW-1:0] a, input logic [31:0] d);
        wr_en[port]              = 1'b1;
        wr_addr[port*AW +: AW]   = a;
        wr_data[port*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd(5'd5, 5'd0);
        check("rst_data5", rd_data[31:0], 32'h0);
        check("rst_busy5", {31'b0, rd_busy[0]}, 32'h0);
        check("rst_any",   {31'b0, any_busy}, 32'h0);

        // 1: write x5, then reset with a write and issue pending that must be dropped
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle();
        rd(5'd5, 5'd0);
        check("t1_pre_data", rd_data[31:0], 32'hDEADBEEF);
        reset = 1'b1;
        wr(0, 5'd5, 32'h12345678);
        iss_en = 1'b1;
        iss_rd = 5'd6;
        tick();
        reset = 1'b0;
        idle();
        rd(5'd5, 5'd6);
        check("t1_data5",  rd_data[31:0], 32'h0);
        check("t1_busy5",  {31'b0, rd_busy[0]}, 32'h0);
        check("t1_busy6",  {31'b0, rd_busy[1]}, 32'h0);
        check("t1_any",    {31'b0, any_busy}, 32'h0);

        // 2: x0 is immutable and never busy
        wr(1, 5'd0, 32'h1234);
        iss_en = 1'b1;
        iss_rd = 5'd0;
        tick();
        idle();
        rd(5'd0, 5'd0);
        check("t2_data0",  rd_data[31:0], 32'h0);
        check("t2_data0b", rd_data[63:32], 32'h0);
        check("t2_busy0",  {31'b0, rd_busy[0]}, 32'h0);
        check("t2_any",    {31'b0, any_busy}, 32'h0);

        // 3: same-address writes, highest port wins
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick();
        idle();
        rd(5'd0, 5'd7);
        check("t3_data7", rd_data[63:32], 32'h22);

        // 4: issue x3, read busy, then writeback clears it
        iss_en = 1'b1;
        iss_rd = 5'd3;
        tick();
        idle();
        rd(5'd3, 5'd3);
        check("t4_busy_t1", {31'b0, rd_busy[1]}, 32'h1);
        check("t4_any_t1",  {31'b0, any_busy}, 32'h1);
        tick();
        check("t4_busy_t2", {31'b0, rd_busy[0]}, 32'h1);
        wr(0, 5'd3, 32'hAA);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("t4_busy_wr", {31'b0, rd_busy[0]}, 32'h0);
`else
        check("t4_busy_wr", {31'b0, rd_busy[0]}, 32'h1);
`endif
        tick();
        idle();
        rd(5'd3, 5'd3);
        check("t4_busy_t3", {31'b0, rd_busy[0]}, 32'h0);
        check("t4_data_t3", rd_data[31:0], 32'hAA);
        check("t4_any_t3",  {31'b0, any_busy}, 32'h0);

        // 5: issue and write the same register in one cycle; set wins, data lands
        iss_en = 1'b1;
        iss_rd = 5'd9;
        wr(1, 5'd9, 32'h55);
        tick();
        idle();
        rd(5'd9, 5'd0);
        check("t5_data9", rd_data[31:0], 32'h55);
        check("t5_busy9", {31'b0, rd_busy[0]}, 32'h1);
        check("t5_any",   {31'b0, any_busy}, 32'h1);
        wr(0, 5'd9, 32'h56);
        tick();
        idle();
        rd(5'd9, 5'd0);
        check("t5_clr_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("t5_clr_any",  {31'b0, any_busy}, 32'h0);

        // 6: write-while-read forwarding behaviour
        wr(0, 5'd4, 32'h10);
        tick();
        idle();
        wr(1, 5'd4, 32'h77);
        rd(5'd4, 5'd7);
`ifdef REGFILE_BYPASS_EN
        check("t6_same_cycle", rd_data[31:0], 32'h77);
`else
        check("t6_same_cycle", rd_data[31:0], 32'h10);
`endif
        check("t6_port1_other", rd_data[63:32], 32'h22);
        tick();
        idle();
        rd(5'd4, 5'd4);
        check("t6_next_cycle", rd_data[31:0], 32'h77);
        check("t6_next_port1", rd_data[63:32], 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
